// File: rtl/td4_io_pkg.sv
// Shared types and helpers for the TD4 switch conditioner.
// Holds the per-channel FSM encoding and the counter-width function.
package td4_io_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } td4_state_e;

   // Width for a counter that must reach the largest of three limits.
   function automatic int td4_cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/td4_debounce_ch.sv
// One debounced switch channel: 2-flop sync, stable-count FSM, pulses.
// Auto-repeat counter exists only with TD4_DEBOUNCE_AUTOREPEAT_EN.
module td4_debounce_ch
   import td4_io_pkg::*;
#(
   parameter int STABLE_CNT    = 50000,
   parameter int REPEAT_DELAY  = 500000,
   parameter int REPEAT_PERIOD = 100000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W =
      td4_cnt_w(STABLE_CNT, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic             s1_q, s2_q;
   td4_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   // rep_q: initial delay already elapsed, now counting periods
   logic             rep_q, rep_d;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
         rcnt_q  <= '0;
         rep_q   <= 1'b0;
`endif
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
         rcnt_q  <= rcnt_d;
         rep_q   <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
      rcnt_d  = rcnt_q;
      rep_d   = rep_q;
`endif
      unique case (state_q)
         IDLE_LO: begin
            if (s2_q) begin
               state_d = CHK_HI;
               cnt_d   = '0;
            end
         end
         CHK_HI: begin
            if (!s2_q) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = IDLE_HI;
               lvl_d   = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         IDLE_HI: begin
            if (!s2_q) begin
               state_d = CHK_LO;
               cnt_d   = '0;
            end else begin
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
               if ((!rep_q && rcnt_q == DELAY_LAST) ||
                   (rep_q && rcnt_q == PERIOD_LAST)) begin
                  rise_d = 1'b1;
                  rcnt_d = '0;
                  rep_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + ONE;
               end
`endif
            end
         end
         CHK_LO: begin
            if (s2_q) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = IDLE_LO;
               lvl_d   = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
               rcnt_d  = '0;
               rep_d   = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/td4_switch_debounce.sv
// N-channel switch conditioner; channel 0 rise is the single-step enable.
// Optional auto-repeat: define TD4_DEBOUNCE_AUTOREPEAT_EN.
module td4_switch_debounce
   import td4_io_pkg::*;
#(
   parameter int CH            = 2,
   parameter int STABLE_CNT    = 50000,
   parameter int REPEAT_DELAY  = 500000,
   parameter int REPEAT_PERIOD = 100000
) (
   input  logic          clk,
   input  logic          RESET,
   input  logic [CH-1:0] sw_raw,
   output logic [CH-1:0] sw_lvl,
   output logic [CH-1:0] sw_rise,
   output logic [CH-1:0] sw_fall
);

   for (genvar g = 0; g < CH; g++) begin : g_ch
      td4_debounce_ch #(
         .STABLE_CNT   (STABLE_CNT),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk_i (clk),
         .rst_ni(RESET),
         .raw_i (sw_raw[g]),
         .lvl_o (sw_lvl[g]),
         .rise_o(sw_rise[g]),
         .fall_o(sw_fall[g])
      );
   end

endmodule

// File: tb/tb_td4_switch_debounce.sv
// Randomised and directed bench for td4_switch_debounce.
// Reference: run-length model of the synchronised input per channel.
module tb_td4_switch_debounce;

   localparam int CH = 2;
   localparam int SC = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   localparam int LAT = 3 + SC;

   logic          clk = 1'b0;
   logic          RESET = 1'b0;
   logic [CH-1:0] sw_raw = '0;
   logic [CH-1:0] sw_lvl, sw_rise, sw_fall;

   int checks = 0;
   int failures = 0;

   int ms1 [CH];
   int ms2 [CH];
   int mrun[CH];
   int mk  [CH];
   logic [CH-1:0] m_lvl = '0;
   logic [CH-1:0] m_rise = '0;
   logic [CH-1:0] m_fall = '0;

   td4_switch_debounce #(
      .CH(CH), .STABLE_CNT(SC),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .RESET(RESET), .sw_raw(sw_raw),
      .sw_lvl(sw_lvl), .sw_rise(sw_rise), .sw_fall(sw_fall)
   );

   always #5 clk = ~clk;

   // Level flips once the synchronised input has disagreed with it
   // for SC+1 consecutive samples; the repeat count advances only on
   // samples that agree with a high level after a settled run.
   task automatic model_step();
      for (int c = 0; c < CH; c++) begin
         if (!RESET) begin
            ms1[c] = 0; ms2[c] = 0; mrun[c] = 0; mk[c] = 0;
            m_lvl[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
         end else begin
            int samp;
            samp = ms2[c];
            ms2[c] = ms1[c];
            ms1[c] = int'(sw_raw[c]);
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (samp != int'(m_lvl[c])) begin
               mrun[c]++;
               if (mrun[c] == SC + 1) begin
                  m_lvl[c] = (samp != 0);
                  if (samp != 0) m_rise[c] = 1'b1;
                  else m_fall[c] = 1'b1;
                  mrun[c] = 0;
                  mk[c] = 0;
               end
            end else begin
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
               if (m_lvl[c] && mrun[c] == 0) begin
                  mk[c]++;
                  if (mk[c] == RD || (mk[c] > RD && (mk[c] - RD) % RP == 0))
                     m_rise[c] = 1'b1;
               end
`endif
               mrun[c] = 0;
            end
            if (!m_lvl[c]) mk[c] = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [CH-1:0] raw);
      sw_raw = raw;
      RESET = 1'b0;
      repeat (2) tick();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      int first;
      sw_raw = 2'b11;
      RESET = 1'b0;
      repeat (2) tick();
      checks++;
      if ({sw_lvl, sw_rise, sw_fall} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000000",
                  {sw_lvl, sw_rise, sw_fall});
      end
      RESET = 1'b1;
      first = -1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (sw_rise[0] && first < 0) first = t;
         checks++;
         if ({sw_lvl, sw_rise, sw_fall} !== {m_lvl, m_rise, m_fall}) begin
            failures++;
            $display("FAIL reset_model t=%0d got=%b exp=%b", t,
                     {sw_lvl, sw_rise, sw_fall}, {m_lvl, m_rise, m_fall});
         end
      end
      checks++;
      if (first !== LAT) begin
         failures++;
         $display("FAIL reset_first_rise got=%0d exp=%0d", first, LAT);
      end
   endtask

   task automatic test_clean_press();
      int at, n;
      do_reset(2'b00);
      for (int ph = 0; ph < 2; ph++) begin
         sw_raw = (ph == 0) ? 2'b01 : 2'b00;
         at = -1;
         n = 0;
         for (int t = 1; t <= 12; t++) begin
            tick();
            if ((ph == 0 && sw_rise[0]) || (ph == 1 && sw_fall[0])) begin
               n++;
               if (at < 0) at = t;
            end
            checks++;
            if ({sw_lvl, sw_rise, sw_fall} !== {m_lvl, m_rise, m_fall}) begin
               failures++;
               $display("FAIL press_model ph=%0d t=%0d got=%b exp=%b", ph, t,
                        {sw_lvl, sw_rise, sw_fall}, {m_lvl, m_rise, m_fall});
            end
         end
         checks++;
         if (at !== LAT || n !== 1 || sw_lvl[0] !== (ph == 0)) begin
            failures++;
            $display("FAIL press_edge ph=%0d got at=%0d n=%0d lvl=%b exp at=%0d n=1",
                     ph, at, n, sw_lvl[0], LAT);
         end
      end
   endtask

   task automatic test_bounce();
      int n, at;
      do_reset(2'b00);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         sw_raw[0] = (i % 2 == 0);
         repeat (2) begin
            tick();
            if (sw_rise[0] || sw_fall[0] || sw_lvl[0]) n++;
         end
      end
      checks++;
      if (n !== 0) begin
         failures++;
         $display("FAIL bounce_quiet got=%0d exp=0", n);
      end
      sw_raw[0] = 1'b1;
      at = -1;
      n = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (sw_rise[0]) begin
            n++;
            if (at < 0) at = t;
         end
      end
      checks++;
      if (at !== LAT || n !== 1) begin
         failures++;
         $display("FAIL bounce_rise got at=%0d n=%0d exp at=%0d n=1", at, n, LAT);
      end
   endtask

   task automatic test_simultaneous();
      int ev;
      do_reset(2'b00);
      sw_raw = 2'b11;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (t == LAT) begin
            checks++;
            if (sw_rise !== 2'b11) begin
               failures++;
               $display("FAIL simul_rise got=%b exp=11", sw_rise);
            end
         end
         if (t == LAT + 1) begin
            checks++;
            if (sw_rise !== 2'b00) begin
               failures++;
               $display("FAIL simul_one_cycle got=%b exp=00", sw_rise);
            end
         end
      end
      ev = 0;
      sw_raw = 2'b01;
      repeat (3) begin
         tick();
         if (sw_rise[1] || sw_fall[1]) ev++;
      end
      sw_raw = 2'b11;
      repeat (8) begin
         tick();
         if (sw_rise[1] || sw_fall[1]) ev++;
      end
      checks++;
      if (ev !== 0 || sw_lvl !== 2'b11) begin
         failures++;
         $display("FAIL glitch_ch1 got ev=%0d lvl=%b exp ev=0 lvl=11", ev, sw_lvl);
      end
   endtask

   task automatic test_reset_midfilter();
      int at;
      do_reset(2'b00);
      sw_raw = 2'b01;
      repeat (5) tick();
      RESET = 1'b0;
      repeat (2) tick();
      checks++;
      if (sw_lvl !== 2'b00) begin
         failures++;
         $display("FAIL midreset_lvl got=%b exp=00", sw_lvl);
      end
      RESET = 1'b1;
      at = -1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (sw_rise[0] && at < 0) at = t;
      end
      checks++;
      if (at !== LAT) begin
         failures++;
         $display("FAIL midreset_latency got=%0d exp=%0d", at, LAT);
      end
   endtask

   task automatic test_autorepeat();
      int n, nexp;
      logic e;
      do_reset(2'b00);
      sw_raw = 2'b01;
      n = 0;
      nexp = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         e = (t == LAT);
`ifdef TD4_DEBOUNCE_AUTOREPEAT_EN
         if (t - LAT == RD || (t - LAT > RD && (t - LAT - RD) % RP == 0))
            e = 1'b1;
`endif
         if (e) nexp++;
         if (sw_rise[0]) n++;
         checks++;
         if (sw_rise[0] !== e) begin
            failures++;
            $display("FAIL repeat_pulse t=%0d got=%b exp=%b", t, sw_rise[0], e);
         end
      end
      checks++;
      if (n !== nexp) begin
         failures++;
         $display("FAIL repeat_count got=%0d exp=%0d", n, nexp);
      end
   endtask

   task automatic test_random();
      int left[CH];
      do_reset(2'b00);
      for (int c = 0; c < CH; c++) left[c] = 1;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++) begin
            left[c]--;
            if (left[c] <= 0) begin
               sw_raw[c] = ~sw_raw[c];
               left[c] = ($urandom_range(0, 3) == 0) ?
                         int'($urandom_range(8, 30)) : int'($urandom_range(1, 6));
            end
         end
         RESET = ($urandom_range(0, 299) != 0);
         tick();
         checks++;
         if ({sw_lvl, sw_rise, sw_fall} !== {m_lvl, m_rise, m_fall}) begin
            failures++;
            $display("FAIL random_model i=%0d got=%b exp=%b", i,
                     {sw_lvl, sw_rise, sw_fall}, {m_lvl, m_rise, m_fall});
         end
      end
      RESET = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_reset_midfilter();
      test_autorepeat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
